// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the instruction fetch front end
package mips_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO holding {pc, instr} pairs; flush wins over push
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  fetch_entry_t     i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push & ~i_flush;
    assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage is never reset; the top masks the head whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC generation, instruction RAM request issue and prefetch buffering
module inst_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    localparam int         CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               inst_ram_ena,
    output logic [31:0]        inst_ram_addr,
    input  logic [INSTR_W-1:0] inst_ram_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [CNT_W-1:0]   fifo_level
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;

    logic [CNT_W-1:0] w_level;
    logic [CNT_W:0]   w_credit_used;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;

    // Occupancy plus the outstanding RAM read must leave room, so a return can always be stored.
    assign w_credit_used = {1'b0, w_level} + (CNT_W + 1)'(r_inflight);
    assign w_issue       = (r_state == S_RUN) & ~redirect
                         & (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    assign w_push      = r_inflight & ~redirect;
    assign w_push_data = '{pc: r_inflight_pc, instr: inst_ram_rdata};
    assign w_valid     = (w_level != '0) & ~redirect;
    assign w_pop       = w_valid & instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= S_RUN;
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            if (redirect)
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_issue)
                r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head      (w_head),
        .o_level     (w_level)
    );

    assign inst_ram_ena  = w_issue;
    assign inst_ram_addr = r_fetch_pc;
    assign instr_valid   = w_valid;
    assign instr         = w_valid ? w_head.instr : '0;
    assign instr_pc      = w_valid ? w_head.pc : '0;
    assign fifo_level    = w_level;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed vector bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        inst_ram_ena;
    logic [31:0] inst_ram_addr;
    logic [31:0] inst_ram_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_level;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        ena;
        logic [31:0] addr;
        logic        val;
        logic [31:0] pc;
        logic [3:0]  lvl;
    } vec_t;

    localparam int NV = 48;
    vec_t tv [NV];

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_ram_ena   (inst_ram_ena),
        .inst_ram_addr  (inst_ram_addr),
        .inst_ram_rdata (inst_ram_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word i holds i; garbage when not read
    always @(posedge clk) begin
        if (inst_ram_ena) inst_ram_rdata <= inst_ram_addr >> 2;
        else              inst_ram_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic e, input logic [31:0] a, input logic vl,
                                input logic [31:0] p, input logic [3:0] l);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.rd = rd; t.rpc = rpc;
        t.ena = e; t.addr = a; t.val = vl; t.pc = p; t.lvl = l;
        return t;
    endfunction

    logic [31:0] exp_next;
    logic        hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    int          n_del;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        inst_ram_rdata = '0;

        //           rst rdy rd rpc            ena addr           val pc             lvl
        tv[0]  = mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[1]  = mk(1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0);
        tv[2]  = mk(1, 1, 0, 32'h0,         1, 32'h4,         0, 32'h0,         0);
        tv[3]  = mk(1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0,         1);
        tv[4]  = mk(1, 1, 0, 32'h0,         1, 32'hC,         1, 32'h4,         1);
        tv[5]  = mk(1, 1, 0, 32'h0,         1, 32'h10,        1, 32'h8,         1);
        tv[6]  = mk(1, 1, 0, 32'h0,         1, 32'h14,        1, 32'hC,         1);
        tv[7]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[8]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[9]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[10] = mk(1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0);
        tv[11] = mk(1, 0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         0);
        tv[12] = mk(1, 0, 0, 32'h0,         1, 32'h8,         1, 32'h0,         1);
        tv[13] = mk(1, 0, 0, 32'h0,         1, 32'hC,         1, 32'h0,         2);
        tv[14] = mk(1, 0, 0, 32'h0,         0, 32'h10,        1, 32'h0,         3);
        for (int i = 15; i < 19; i++)
            tv[i] = mk(1, 0, 0, 32'h0,      0, 32'h10,        1, 32'h0,         4);
        tv[19] = mk(1, 1, 0, 32'h0,         0, 32'h10,        1, 32'h0,         4);
        tv[20] = mk(1, 1, 0, 32'h0,         1, 32'h10,        1, 32'h4,         3);
        tv[21] = mk(1, 1, 0, 32'h0,         1, 32'h14,        1, 32'h8,         2);
        tv[22] = mk(1, 1, 0, 32'h0,         1, 32'h18,        1, 32'hC,         2);
        tv[23] = mk(1, 0, 0, 32'h0,         1, 32'h1C,        1, 32'h10,        2);
        tv[24] = mk(1, 1, 1, 32'h103,       0, 32'h20,        0, 32'h0,         3);
        tv[25] = mk(1, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0,         0);
        tv[26] = mk(1, 1, 0, 32'h0,         1, 32'h104,       0, 32'h0,         0);
        tv[27] = mk(1, 1, 0, 32'h0,         1, 32'h108,       1, 32'h100,       1);
        tv[28] = mk(1, 1, 0, 32'h0,         1, 32'h10C,       1, 32'h104,       1);
        tv[29] = mk(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h110,       0, 32'h0,         1);
        tv[30] = mk(1, 1, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0,         0);
        tv[31] = mk(1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        tv[32] = mk(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFF8, 1);
        tv[33] = mk(1, 1, 0, 32'h0,         1, 32'h4,         1, 32'hFFFF_FFFC, 1);
        tv[34] = mk(1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h0,         1);
        tv[35] = mk(1, 1, 0, 32'h0,         1, 32'hC,         1, 32'h4,         1);
        tv[36] = mk(1, 1, 1, 32'h40,        0, 32'h10,        0, 32'h0,         1);
        tv[37] = mk(1, 1, 1, 32'h80,        0, 32'h40,        0, 32'h0,         0);
        tv[38] = mk(1, 1, 0, 32'h0,         1, 32'h80,        0, 32'h0,         0);
        tv[39] = mk(1, 1, 0, 32'h0,         1, 32'h84,        0, 32'h0,         0);
        tv[40] = mk(1, 1, 0, 32'h0,         1, 32'h88,        1, 32'h80,        1);
        tv[41] = mk(1, 1, 0, 32'h0,         1, 32'h8C,        1, 32'h84,        1);
        tv[42] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[43] = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
        tv[44] = mk(1, 1, 1, 32'h200,       0, 32'h0,         0, 32'h0,         0);
        tv[45] = mk(1, 1, 0, 32'h0,         1, 32'h200,       0, 32'h0,         0);
        tv[46] = mk(1, 1, 0, 32'h0,         1, 32'h204,       0, 32'h0,         0);
        tv[47] = mk(1, 1, 0, 32'h0,         1, 32'h208,       1, 32'h200,       1);

        repeat (3) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst         = tv[i].rst;
            instr_ready = tv[i].rdy;
            redirect    = tv[i].rd;
            redirect_pc = tv[i].rpc;
            #1;
            check($sformatf("v%0d ena", i),   32'(inst_ram_ena), 32'(tv[i].ena));
            check($sformatf("v%0d addr", i),  inst_ram_addr,     tv[i].addr);
            check($sformatf("v%0d valid", i), 32'(instr_valid),  32'(tv[i].val));
            check($sformatf("v%0d pc", i),    instr_pc,          tv[i].pc);
            check($sformatf("v%0d instr", i), instr,             tv[i].val ? (tv[i].pc >> 2) : 32'h0);
            check($sformatf("v%0d level", i), 32'(fifo_level),   32'(tv[i].lvl));
        end

        // Random stalls and redirects against an in-order stream model
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_next = 32'h0;
        hold = 1'b0;
        hold_pc = '0;
        hold_instr = '0;
        n_del = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            #1;
            if (hold && !redirect) begin
                check("stall valid", 32'(instr_valid), 32'h1);
                check("stall pc", instr_pc, hold_pc);
                check("stall instr", instr, hold_instr);
            end
            if (redirect) check("redirect valid", 32'(instr_valid), 32'h0);
            if (instr_valid && instr_ready) begin
                check("stream pc", instr_pc, exp_next);
                check("stream instr", instr, instr_pc >> 2);
                exp_next = exp_next + 32'd4;
                n_del++;
            end
            if (fifo_level > 3'd4) check("level bound", 32'(fifo_level), 32'h4);
            if (redirect) exp_next = {redirect_pc[31:2], 2'b00};
            hold       = instr_valid && !instr_ready;
            hold_pc    = instr_pc;
            hold_instr = instr;
        end
        check("stream progress", 32'(n_del > 100), 32'h1);

        // Asynchronous reset in the high phase, no clock edge in between
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async ena", 32'(inst_ram_ena), 32'h0);
        check("async valid", 32'(instr_valid), 32'h0);
        check("async level", 32'(fifo_level), 32'h0);
        check("async addr", inst_ram_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
